// File: rtl/arb_nmks_rr.sv
// arb_nmks_rr -- N-master / K-slave MemSplit32 crossbar with per-slave
// round-robin arbitration and in-order read-response routing.
//
// Optional feature macro: ARB_NMKS_DECERR_EN
//   defined   : addresses whose slave-select field is >= NUM_S reach an
//               internal error slave. It acks at once, drops writes, and
//               answers reads one cycle later with 32'hDEAD_BEEF.
//   undefined : such addresses alias to slave NUM_S-1.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   m_req_i/m_we_i          per-master request / write enable
//   m_addr_bi/m_be_bi/m_wdata_bi  per-master address, byte enables, write data
//   m_ack_o                 request accepted (same cycle as slave ack)
//   m_resp_o/m_rdata_bo     read data valid / read data, routed back in order
//   s_req_o/s_we_o/s_addr_bo/s_be_bo/s_wdata_bo  per-slave request bus
//   s_ack_i                 slave accepted request
//   s_resp_i/s_rdata_bi     slave read data valid / read data
module arb_nmks_rr #(
    parameter int NUM_M  = 2,
    parameter int NUM_S  = 3,
    parameter int SEL_LO = 20,
    parameter int SEL_W  = 2,
    parameter int OUTST  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_M-1:0]      m_req_i,
    input  logic [NUM_M-1:0]      m_we_i,
    input  logic [NUM_M*32-1:0]   m_addr_bi,
    input  logic [NUM_M*4-1:0]    m_be_bi,
    input  logic [NUM_M*32-1:0]   m_wdata_bi,
    output logic [NUM_M-1:0]      m_ack_o,
    output logic [NUM_M-1:0]      m_resp_o,
    output logic [NUM_M*32-1:0]   m_rdata_bo,
    output logic [NUM_S-1:0]      s_req_o,
    output logic [NUM_S-1:0]      s_we_o,
    output logic [NUM_S*32-1:0]   s_addr_bo,
    output logic [NUM_S*4-1:0]    s_be_bo,
    output logic [NUM_S*32-1:0]   s_wdata_bo,
    input  logic [NUM_S-1:0]      s_ack_i,
    input  logic [NUM_S-1:0]      s_resp_i,
    input  logic [NUM_S*32-1:0]   s_rdata_bi
);

`ifdef ARB_NMKS_DECERR_EN
    localparam int NS_INT = NUM_S + 1;   // last internal slave is the error slave
`else
    localparam int NS_INT = NUM_S;
`endif
    localparam int MI_W  = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int SI_W  = $clog2(NUM_S + 1);
    localparam int CNT_W = $clog2(OUTST + 1);
    localparam int PTR_W = $clog2(OUTST);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(OUTST);
    localparam logic [PTR_W:0]   FILL_MAX = (PTR_W+1)'(OUTST);

    typedef enum logic {IDLE, LOCK} state_t;

    // internal slave-side view (real slaves plus optional error slave)
    logic [NS_INT-1:0] s_ack_int, s_resp_int;
    logic [31:0]       s_rdata_int [NS_INT];

    logic [SI_W-1:0]   dec         [NUM_M];
    logic [NUM_M-1:0]  elig        [NS_INT];
    logic [MI_W-1:0]   gnt_idx     [NS_INT];
    logic [MI_W-1:0]   head        [NS_INT];
    logic [NS_INT-1:0] s_req_int, accept, push_v, pop_v, fifo_full, fifo_empty;

    logic [CNT_W-1:0]  cnt_reg     [NUM_M];
    logic [SI_W-1:0]   last_reg    [NUM_M];
    logic [SI_W-1:0]   last_next   [NUM_M];
    logic [NUM_M-1:0]  push_m, pop_m;

    genvar gi, gj;

    generate
        for (gi = 0; gi < NUM_S; gi++) begin : g_rdata
            assign s_rdata_int[gi] = s_rdata_bi[gi*32 +: 32];
        end
    endgenerate

`ifdef ARB_NMKS_DECERR_EN
    logic err_resp_reg;

    assign s_ack_int             = {1'b1, s_ack_i};
    assign s_resp_int            = {err_resp_reg, s_resp_i};
    assign s_rdata_int[NUM_S]    = 32'hDEAD_BEEF;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) err_resp_reg <= 1'b0;
        else       err_resp_reg <= push_v[NUM_S];
    end
`else
    assign s_ack_int  = s_ack_i;
    assign s_resp_int = s_resp_i;
`endif

    // address decode: out-of-range select goes to the error slave or aliases
    generate
        for (gi = 0; gi < NUM_M; gi++) begin : g_dec
            logic [SEL_W-1:0] sel;
            assign sel = m_addr_bi[gi*32+SEL_LO +: SEL_W];
`ifdef ARB_NMKS_DECERR_EN
            assign dec[gi] = (int'(sel) >= NUM_S) ? SI_W'(NUM_S) : SI_W'(sel);
`else
            assign dec[gi] = (int'(sel) >= NUM_S) ? SI_W'(NUM_S - 1) : SI_W'(sel);
`endif
        end
    endgenerate

    // A read may only target the slave that already holds this master's
    // in-flight reads, which keeps responses to each master in order.
    generate
        for (gi = 0; gi < NS_INT; gi++) begin : g_elig
            for (gj = 0; gj < NUM_M; gj++) begin : g_m
                assign elig[gi][gj] = ~rst_i & m_req_i[gj] & (dec[gj] == SI_W'(gi)) &
                    (m_we_i[gj] | (~fifo_full[gi] &
                        ((cnt_reg[gj] == '0) |
                         ((last_reg[gj] == SI_W'(gi)) & (cnt_reg[gj] != CNT_MAX)))));
            end
        end
    endgenerate

    generate
        for (gi = 0; gi < NS_INT; gi++) begin : g_slv
            state_t            state_reg, state_next;
            logic [MI_W-1:0]   owner_reg, owner_next, rr_ptr_reg, pick;
            logic              found;
            logic [MI_W-1:0]   fifo_mem [OUTST];
            logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
            logic [PTR_W:0]    fill_reg;

            // first eligible master at or after the round-robin pointer
            always_comb begin
                int idx;
                idx   = 0;
                pick  = '0;
                found = 1'b0;
                for (int k = 0; k < NUM_M; k++) begin
                    idx = int'(rr_ptr_reg) + k;
                    if (idx >= NUM_M) idx = idx - NUM_M;
                    if (!found && elig[gi][idx]) begin
                        found = 1'b1;
                        pick  = MI_W'(idx);
                    end
                end
            end

            assign gnt_idx[gi]   = (state_reg == LOCK) ? owner_reg : pick;
            assign s_req_int[gi] = (state_reg == LOCK) | found;
            assign accept[gi]    = s_req_int[gi] & s_ack_int[gi];
            assign push_v[gi]    = accept[gi] & ~m_we_i[gnt_idx[gi]];
            assign pop_v[gi]     = s_resp_int[gi] & ~fifo_empty[gi];
            assign fifo_full[gi]  = (fill_reg == FILL_MAX);
            assign fifo_empty[gi] = (fill_reg == '0);
            assign head[gi]       = fifo_mem[rd_ptr_reg];

            always_comb begin
                state_next = state_reg;
                owner_next = owner_reg;
                case (state_reg)
                    IDLE: if (found && !s_ack_int[gi]) begin
                        state_next = LOCK;
                        owner_next = pick;
                    end
                    LOCK: if (s_ack_int[gi]) state_next = IDLE;
                    default: state_next = IDLE;
                endcase
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    state_reg  <= IDLE;
                    owner_reg  <= '0;
                    rr_ptr_reg <= '0;
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    fill_reg   <= '0;
                end else begin
                    state_reg <= state_next;
                    owner_reg <= owner_next;
                    if (accept[gi])
                        rr_ptr_reg <= (int'(gnt_idx[gi]) == NUM_M - 1) ? '0 : gnt_idx[gi] + 1'b1;
                    if (push_v[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    if (pop_v[gi])  rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    fill_reg <= fill_reg + (PTR_W+1)'(push_v[gi]) - (PTR_W+1)'(pop_v[gi]);
                end
            end

            always_ff @(posedge clk_i) begin
                if (push_v[gi]) fifo_mem[wr_ptr_reg] <= gnt_idx[gi];
            end
        end
    endgenerate

    generate
        for (gi = 0; gi < NUM_S; gi++) begin : g_sbus
            assign s_req_o[gi]             = s_req_int[gi];
            assign s_we_o[gi]              = s_req_int[gi] & m_we_i[gnt_idx[gi]];
            assign s_addr_bo[gi*32 +: 32]  = s_req_int[gi] ? m_addr_bi[int'(gnt_idx[gi])*32 +: 32] : '0;
            assign s_be_bo[gi*4 +: 4]      = s_req_int[gi] ? m_be_bi[int'(gnt_idx[gi])*4 +: 4] : '0;
            assign s_wdata_bo[gi*32 +: 32] = s_req_int[gi] ? m_wdata_bi[int'(gnt_idx[gi])*32 +: 32] : '0;
        end
    endgenerate

    // master-side ack and response routing
    always_comb begin
        m_ack_o    = '0;
        m_resp_o   = '0;
        m_rdata_bo = '0;
        for (int s = 0; s < NS_INT; s++) begin
            if (accept[s]) m_ack_o[gnt_idx[s]] = 1'b1;
            if (pop_v[s]) begin
                m_resp_o[head[s]]                   = 1'b1;
                m_rdata_bo[int'(head[s])*32 +: 32]  = s_rdata_int[s];
            end
        end
    end

    // per-master outstanding-read bookkeeping
    always_comb begin
        push_m = '0;
        pop_m  = '0;
        for (int i = 0; i < NUM_M; i++) last_next[i] = last_reg[i];
        for (int s = 0; s < NS_INT; s++) begin
            if (push_v[s]) begin
                push_m[gnt_idx[s]]    = 1'b1;
                last_next[gnt_idx[s]] = SI_W'(s);
            end
            if (pop_v[s]) pop_m[head[s]] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_M; i++) begin
                cnt_reg[i]  <= '0;
                last_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_M; i++) begin
                cnt_reg[i]  <= cnt_reg[i] + CNT_W'(push_m[i]) - CNT_W'(pop_m[i]);
                last_reg[i] <= last_next[i];
            end
        end
    end

endmodule

// File: tb/tb_arb_nmks_rr.sv
// tb_arb_nmks_rr -- randomized bench for arb_nmks_rr against a queue-based
// reference model of the crossbar (round-robin grant, lock on stalled ack,
// per-slave in-order response queues, per-master outstanding limits).
module tb_arb_nmks_rr;
    localparam int NUM_M  = 2;
    localparam int NUM_S  = 3;
    localparam int SEL_LO = 20;
    localparam int SEL_W  = 2;
    localparam int OUTST  = 4;
`ifdef ARB_NMKS_DECERR_EN
    localparam int NSI = NUM_S + 1;
`else
    localparam int NSI = NUM_S;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_M-1:0]     m_req_i, m_we_i, m_ack_o, m_resp_o;
    logic [NUM_M*32-1:0]  m_addr_bi, m_wdata_bi, m_rdata_bo;
    logic [NUM_M*4-1:0]   m_be_bi;
    logic [NUM_S-1:0]     s_req_o, s_we_o, s_ack_i, s_resp_i;
    logic [NUM_S*32-1:0]  s_addr_bo, s_wdata_bo, s_rdata_bi;
    logic [NUM_S*4-1:0]   s_be_bo;

    always #5 clk = ~clk;

    arb_nmks_rr #(.NUM_M(NUM_M), .NUM_S(NUM_S), .SEL_LO(SEL_LO), .SEL_W(SEL_W), .OUTST(OUTST)) dut (
        .clk_i(clk), .rst_i(rst),
        .m_req_i(m_req_i), .m_we_i(m_we_i), .m_addr_bi(m_addr_bi), .m_be_bi(m_be_bi),
        .m_wdata_bi(m_wdata_bi), .m_ack_o(m_ack_o), .m_resp_o(m_resp_o), .m_rdata_bo(m_rdata_bo),
        .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_bo(s_addr_bo), .s_be_bo(s_be_bo),
        .s_wdata_bo(s_wdata_bo), .s_ack_i(s_ack_i), .s_resp_i(s_resp_i), .s_rdata_bi(s_rdata_bi)
    );

    // reference model state
    int          rr [NSI];
    bit          lk [NSI];
    int          lk_own [NSI];
    int          q [NSI][$];
    int          cnt [NUM_M];
    int          last [NUM_M];
    bit          err_pend;
    // master and slave stimulus state
    bit          pend [NUM_M];
    bit          pwe [NUM_M];
    logic [31:0] paddr [NUM_M];
    logic [31:0] pwd [NUM_M];
    logic [3:0]  pbe [NUM_M];
    bit          sack [NSI];
    bit          sresp [NSI];
    logic [31:0] srd [NSI];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic int target(input logic [31:0] a);
        int sel;
        sel = int'(a[SEL_LO +: SEL_W]);
`ifdef ARB_NMKS_DECERR_EN
        if (sel >= NUM_S) return NUM_S;
`else
        if (sel >= NUM_S) return NUM_S - 1;
`endif
        return sel;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < NSI; s++) begin
            rr[s] = 0; lk[s] = 0; lk_own[s] = 0; q[s].delete();
        end
        for (int m = 0; m < NUM_M; m++) begin
            cnt[m] = 0; last[m] = 0;
        end
        err_pend = 0;
    endtask

    task automatic step(input int cyc, input bit r, input int preq, input int pread,
                        input int pack, input int presp);
        int          g [NSI];
        bit          rq [NSI];
        bit          acc [NSI];
        bit          pp [NSI];
        int          hd [NSI];
        logic [NUM_M-1:0] e_ack, e_resp;
        logic [31:0] e_rd [NUM_M];
        int          m;

        @(negedge clk);
        rst = r;
        for (int i = 0; i < NUM_M; i++) begin
            if (!pend[i] && $urandom_range(99) < preq) begin
                pend[i]  = 1;
                pwe[i]   = ($urandom_range(99) >= pread);
                paddr[i] = $urandom;
                pbe[i]   = 4'($urandom);
                pwd[i]   = $urandom;
            end
            m_req_i[i]             = pend[i];
            m_we_i[i]              = pwe[i];
            m_addr_bi[i*32 +: 32]  = paddr[i];
            m_be_bi[i*4 +: 4]      = pbe[i];
            m_wdata_bi[i*32 +: 32] = pwd[i];
        end
        for (int s = 0; s < NUM_S; s++) begin
            sack[s]  = ($urandom_range(99) < pack);
            sresp[s] = ($urandom_range(99) < presp);
            srd[s]   = $urandom;
            s_ack_i[s]              = sack[s];
            s_resp_i[s]             = sresp[s];
            s_rdata_bi[s*32 +: 32]  = srd[s];
        end
`ifdef ARB_NMKS_DECERR_EN
        sack[NUM_S]  = 1;
        sresp[NUM_S] = err_pend;
        srd[NUM_S]   = 32'hDEAD_BEEF;
`endif
        #1;
        if (r) begin
            check("rst_s_req", 64'(s_req_o), 64'd0);
            check("rst_m_ack", 64'(m_ack_o), 64'd0);
            check("rst_m_resp", 64'(m_resp_o), 64'd0);
            model_reset();
            $display("cyc %0d reset asserted, in-flight reads dropped", cyc);
            return;
        end

        e_ack  = '0;
        e_resp = '0;
        for (int i = 0; i < NUM_M; i++) e_rd[i] = '0;
        for (int s = 0; s < NSI; s++) begin
            rq[s] = 0; g[s] = 0; hd[s] = 0;
            if (lk[s]) begin
                rq[s] = 1; g[s] = lk_own[s];
            end else begin
                for (int k = 0; k < NUM_M; k++) begin
                    m = (rr[s] + k) % NUM_M;
                    if (!rq[s] && pend[m] && target(paddr[m]) == s &&
                        (pwe[m] || (q[s].size() < OUTST &&
                                    (cnt[m] == 0 || (last[m] == s && cnt[m] < OUTST))))) begin
                        rq[s] = 1; g[s] = m;
                    end
                end
            end
            acc[s] = rq[s] && sack[s];
            if (acc[s]) e_ack[g[s]] = 1'b1;
            pp[s] = sresp[s] && q[s].size() > 0;
            if (pp[s]) begin
                hd[s] = q[s][0];
                e_resp[hd[s]] = 1'b1;
                e_rd[hd[s]]   = srd[s];
            end
        end

        check("m_ack", 64'(m_ack_o), 64'(e_ack));
        check("m_resp", 64'(m_resp_o), 64'(e_resp));
        for (int i = 0; i < NUM_M; i++)
            if (e_resp[i]) check("m_rdata", 64'(m_rdata_bo[i*32 +: 32]), 64'(e_rd[i]));
        for (int s = 0; s < NUM_S; s++) begin
            check("s_req", 64'(s_req_o[s]), 64'(rq[s]));
            if (rq[s]) begin
                check("s_ctl", 64'({s_we_o[s], s_be_bo[s*4 +: 4], s_addr_bo[s*32 +: 32]}),
                      64'({pwe[g[s]], pbe[g[s]], paddr[g[s]]}));
                if (pwe[g[s]]) check("s_wdata", 64'(s_wdata_bo[s*32 +: 32]), 64'(pwd[g[s]]));
            end
        end

        for (int s = 0; s < NSI; s++) begin
            if (pp[s]) begin
                void'(q[s].pop_front());
                cnt[hd[s]]--;
                $display("cyc %0d RSP s%0d -> m%0d data=%h", cyc, s, hd[s], srd[s]);
            end
        end
`ifdef ARB_NMKS_DECERR_EN
        err_pend = acc[NUM_S] && !pwe[g[NUM_S]];
`endif
        for (int s = 0; s < NSI; s++) begin
            if (acc[s]) begin
                $display("cyc %0d ACC s%0d m%0d %s addr=%h", cyc, s, g[s], pwe[g[s]] ? "WR" : "RD", paddr[g[s]]);
                if (!pwe[g[s]]) begin
                    q[s].push_back(g[s]);
                    cnt[g[s]]++;
                    last[g[s]] = s;
                end
                rr[s]      = (g[s] + 1) % NUM_M;
                lk[s]      = 0;
                pend[g[s]] = 0;
            end else if (rq[s] && !lk[s]) begin
                lk[s]     = 1;
                lk_own[s] = g[s];
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        m_req_i = '0; m_we_i = '0; m_addr_bi = '0; m_be_bi = '0; m_wdata_bi = '0;
        s_ack_i = '0; s_resp_i = '0; s_rdata_bi = '0;
        for (int i = 0; i < NUM_M; i++) begin
            pend[i] = 0; pwe[i] = 0; paddr[i] = '0; pwd[i] = '0; pbe[i] = '0;
        end
        model_reset();
        for (int c = 0; c < 3; c++) step(c, 1'b1, 80, 50, 70, 50);
        for (int c = 0; c < 1500; c++) begin
            if (c < 600)       step(c, c == 300,  60, 50, 70, 50);  // mixed traffic
            else if (c < 1000) step(c, c == 700,  90, 80, 100, 5);  // fill queues, stall reads
            else               step(c, c == 1200, 70, 50, 30, 60);  // slow acks, long locks
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
